// File: rtl/video_timing_fetch.sv
// Programmable video timing generator with frame-buffer pixel fetch.
// Define VIDEO_TIMING_FETCH_TPG_EN to add the colour-bar test pattern.
module video_timing_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int CNT_W    = 11,
  parameter int ADDR_W   = 21,
  parameter int RD_LAT   = 2
) (
  input  logic              clk_low,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [ADDR_W-1:0] line_stride,
`ifdef VIDEO_TIMING_FETCH_TPG_EN
  input  logic              tpg_sel,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [23:0]       rgb,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              frame_start,
  output logic              running
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic             de;
    logic             hs;
    logic             vs;
    logic             fs;
    logic             tpg;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } side_t;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  hx_q, hx_d;
  logic [CNT_W-1:0]  vy_q, vy_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] base_eff, stride_eff;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              active, fstart, h_end, f_end, draw;
  logic              tpg_eff;

  side_t             sb_d;
  side_t             sb_q [RD_LAT+1];
  side_t             sbo;

  logic [23:0]       rgb_q, rgb_d;
  logic              de_q, de_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic [CNT_W-1:0]  pix_x_q, pix_x_d;
  logic [CNT_W-1:0]  pix_y_q, pix_y_d;
  logic              fs_q, fs_d;

  assign active = (state_q != S_IDLE);
  assign h_end  = (hx_q == H_LAST);
  assign f_end  = h_end && (vy_q == V_LAST);
  assign fstart = (state_q == S_RUN) &&
                  (hx_q == '0) && (vy_q == '0);
  assign draw   = active && (hx_q < H_ACT) && (vy_q < V_ACT);

  // Enable only matters when idle or at the last pixel of a frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_RUN;
      S_RUN:   if (!enable) state_d = f_end ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (enable)     state_d = S_RUN;
        else if (f_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hx_d = hx_q;
    vy_d = vy_q;
    if (active) begin
      hx_d = h_end ? '0 : hx_q + CNT_W'(1);
      if (h_end) vy_d = (vy_q == V_LAST) ? '0 : vy_q + CNT_W'(1);
    end
  end

  // Frame-start values bypass their registers so pixel (0,0) uses them.
  assign base_eff   = fstart ? frame_base  : base_q;
  assign stride_eff = fstart ? line_stride : stride_q;

  always_comb begin
    base_d   = base_eff;
    stride_d = stride_eff;
    if (active && h_end && (vy_q < V_ACT))
      base_d = base_eff + stride_eff;
  end

`ifdef VIDEO_TIMING_FETCH_TPG_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic tpg_q, tpg_d;

  assign tpg_eff = fstart ? tpg_sel : tpg_q;
  assign tpg_d   = tpg_eff;

  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) tpg_q <= 1'b0;
    else        tpg_q <= tpg_d;
  end

  function automatic logic [23:0] bar_rgb(
    input logic [CNT_W-1:0] x
  );
    logic [2:0] b;
    b = '0;
    for (int k = 1; k < 8; k++)
      if (x >= CNT_W'(k * BAR_W)) b = 3'(k);
    return {{8{~b[1]}}, {8{~b[2]}}, {8{~b[0]}}};
  endfunction
`else
  assign tpg_eff = 1'b0;
`endif

  always_comb begin
    rd_en_d   = draw && !tpg_eff;
    rd_addr_d = rd_en_d ? base_eff + ADDR_W'(hx_q) : rd_addr_q;
    sb_d.de   = draw;
    sb_d.hs   = active && (hx_q >= HS_BEG) && (hx_q < HS_END);
    sb_d.vs   = active && (vy_q >= VS_BEG) && (vy_q < VS_END);
    sb_d.fs   = fstart;
    sb_d.tpg  = tpg_eff && active;
    sb_d.x    = hx_q;
    sb_d.y    = vy_q;
  end

  assign sbo = sb_q[RD_LAT];

  always_comb begin
    rgb_d = '0;
    if (sbo.de && !sbo.tpg) rgb_d = rd_data;
`ifdef VIDEO_TIMING_FETCH_TPG_EN
    if (sbo.de && sbo.tpg) rgb_d = bar_rgb(sbo.x);
`endif
    de_d    = sbo.de;
    hsync_d = sbo.hs ? HS_ON : !HS_ON;
    vsync_d = sbo.vs ? VS_ON : !VS_ON;
    pix_x_d = sbo.x;
    pix_y_d = sbo.y;
    fs_d    = sbo.fs;
  end

  always_ff @(posedge clk_low or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      hx_q      <= '0;
      vy_q      <= '0;
      base_q    <= '0;
      stride_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) sb_q[i] <= '0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hsync_q   <= !HS_ON;
      vsync_q   <= !VS_ON;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hx_q      <= hx_d;
      vy_q      <= vy_d;
      base_q    <= base_d;
      stride_q  <= stride_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      sb_q[0]   <= sb_d;
      for (int i = 1; i <= RD_LAT; i++) sb_q[i] <= sb_q[i-1];
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      fs_q      <= fs_d;
    end
  end

  assign running     = active;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign rgb         = rgb_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_fetch.sv
// Bench for video_timing_fetch: directed + random stimulus
// against a frame-position reference model with a data=addr memory.
module tb_video_timing_fetch;

`ifdef VIDEO_TIMING_FETCH_TPG_EN
  localparam int HA = 16;
`else
  localparam int HA = 8;
`endif
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 3;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSW = 1;
  localparam int VBP = 2;
  localparam int RDL = 2;
  localparam int HSP = 0;
  localparam int VSP = 1;
  localparam int CW  = 11;
  localparam int AW  = 21;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [AW-1:0] frame_base;
  logic [AW-1:0] line_stride;
`ifdef VIDEO_TIMING_FETCH_TPG_EN
  logic          tpg_sel;
`endif
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [23:0]   rd_data;
  logic [23:0]   rgb;
  logic          de, hsync, vsync, frame_start, running;
  logic [CW-1:0] pix_x, pix_y;

  always #5 clk = ~clk;

  video_timing_fetch #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP), .CNT_W(CW), .ADDR_W(AW),
    .RD_LAT(RDL)
  ) dut (
    .clk_low(clk), .reset(rst_n), .enable(enable),
    .frame_base(frame_base), .line_stride(line_stride),
`ifdef VIDEO_TIMING_FETCH_TPG_EN
    .tpg_sel(tpg_sel),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rgb(rgb), .de(de), .hsync(hsync), .vsync(vsync),
    .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .running(running)
  );

  // Memory returns its own address, RDL cycles after the request.
  logic [AW-1:0] mq [RDL];
  always @(posedge clk) begin
    mq[0] <= rd_addr;
    for (int i = 1; i < RDL; i++) mq[i] <= mq[i-1];
  end
  assign rd_data = 24'(mq[RDL-1]);

  typedef struct {
    bit          draw;
    bit          hs;
    bit          vs;
    bit          fs;
    bit          tpg;
    int          x;
    int          y;
    logic [AW-1:0] addr;
  } rec_t;

  int            checks = 0;
  int            errors = 0;
  bit            m_act;
  int            m_pos;
  logic [AW-1:0] m_fb, m_ls, exp_rdaddr;
  bit            m_tpg;
  rec_t          hist[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] bar_colour(int x);
    case (x / (HA / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r.draw = 0; r.hs = 0; r.vs = 0; r.fs = 0; r.tpg = 0;
    r.x = 0; r.y = 0; r.addr = '0;
    return r;
  endfunction

  task automatic reset_model();
    m_act = 0;
    m_pos = 0;
    exp_rdaddr = '0;
    hist.delete();
    for (int i = 0; i < RDL + 2; i++) hist.push_back(idle_rec());
  endtask

  task automatic chk_reset();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_de", de, 0);
    chk("rst_hsync", hsync, (HSP == 0) ? 1 : 0);
    chk("rst_vsync", vsync, (VSP == 0) ? 1 : 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_running", running, 0);
  endtask

  // One pixel clock: model this cycle, clock, check next cycle.
  task automatic cycle();
    rec_t r, o;
    bit en, hs_e, vs_e;
    logic [23:0] rgb_e;
    r = idle_rec();
    if (m_act) begin
      if (m_pos == 0) begin
        m_fb = frame_base;
        m_ls = line_stride;
`ifdef VIDEO_TIMING_FETCH_TPG_EN
        m_tpg = tpg_sel;
`else
        m_tpg = 0;
`endif
      end
      r.x    = m_pos % HT;
      r.y    = m_pos / HT;
      r.draw = (r.x < HA) && (r.y < VA);
      r.hs   = (r.x >= HA + HFP) && (r.x < HA + HFP + HSW);
      r.vs   = (r.y >= VA + VFP) && (r.y < VA + VFP + VSW);
      r.fs   = (m_pos == 0);
      r.tpg  = m_tpg;
      r.addr = m_fb + AW'(r.y) * m_ls + AW'(r.x);
    end
    hist.push_back(r);
    en = enable;
    @(posedge clk);
    if (!m_act) begin
      if (en) begin m_act = 1; m_pos = 0; end
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0;
      m_act = en;
    end else begin
      m_pos++;
    end
    @(negedge clk);
    if (r.draw && !r.tpg) exp_rdaddr = r.addr;
    chk("rd_en", rd_en, r.draw && !r.tpg);
    chk("rd_addr", rd_addr, exp_rdaddr);
    o = hist[hist.size() - RDL - 2];
    hs_e = o.hs ? (HSP != 0) : (HSP == 0);
    vs_e = o.vs ? (VSP != 0) : (VSP == 0);
    rgb_e = !o.draw ? 24'h0 :
            o.tpg ? bar_colour(o.x) : 24'(o.addr);
    chk("de", de, o.draw);
    chk("hsync", hsync, hs_e);
    chk("vsync", vsync, vs_e);
    chk("pix_x", pix_x, o.x);
    chk("pix_y", pix_y, o.y);
    chk("frame_start", frame_start, o.fs);
    chk("rgb", rgb, rgb_e);
    chk("running", running, m_act);
    while (hist.size() > RDL + 2) void'(hist.pop_front());
  endtask

  task automatic run_to(int target);
    int n = 0;
    while (!(m_act && m_pos == target) && n < 4 * FRAME) begin
      cycle();
      n++;
    end
    checks++;
    if (!(m_act && m_pos == target)) begin
      errors++;
      $error("FAIL run_to: position %0d not reached (at %0d)",
             target, m_pos);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    frame_base = '0;
    line_stride = '0;
`ifdef VIDEO_TIMING_FETCH_TPG_EN
    tpg_sel = 1'b0;
`endif
    reset_model();
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;

    repeat (100) cycle();

    frame_base = 21'h100;
    line_stride = 21'h20;
    enable = 1'b1;
    repeat (FRAME + 20) cycle();

    run_to(FRAME / 2);
    frame_base = 21'h400;
    repeat (FRAME) cycle();

    run_to(HT + 3);
    enable = 1'b0;
    run_to(FRAME - 1);
    enable = 1'b1;
    repeat (FRAME + 5) cycle();

    enable = 1'b0;
    repeat (40) cycle();
    enable = 1'b1;
    repeat (FRAME) cycle();

`ifdef VIDEO_TIMING_FETCH_TPG_EN
    tpg_sel = 1'b1;
    repeat (2 * FRAME) cycle();
    tpg_sel = 1'b0;
`endif

    repeat (2500) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) frame_base = AW'($urandom);
      if ($urandom_range(0, 39) == 0) line_stride = AW'($urandom);
`ifdef VIDEO_TIMING_FETCH_TPG_EN
      if ($urandom_range(0, 99) == 0) tpg_sel = ~tpg_sel;
`endif
      cycle();
    end

    enable = 1'b1;
    run_to(2 * HT + int'($urandom_range(1, HA)));
    rst_n = 1'b0;
    #1;
    chk_reset();
    reset_model();
    @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    repeat (FRAME + 10) cycle();

    enable = 1'b0;
    repeat (FRAME + RDL + 10) cycle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
